// File: rtl/keypad_amount_entry.sv
// 4x4 keypad scanner with press/release debounce and a decimal-to-binary amount accumulator.
// Key codes follow the physical map; the amount saturates by rejecting digits instead of wrapping.
module keypad_amount_entry #(
  parameter int SCAN_DIV_W     = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  input  logic       clear,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] amount,
  output logic [1:0] digit_cnt,
  output logic       overflow,
  output logic       enter
);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} state_t;

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] KEY_MAP [16] = '{
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  logic [SCAN_DIV_W-1:0] r_div;
  logic [3:0]            r_col_s1, r_col_s2;
  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [3:0]            r_cap, w_cap_nxt;
  logic [1:0]            r_row_idx, w_row_idx_nxt;
  logic                  w_kv_nxt;
  logic                  w_tick;
  logic                  w_one_low;
  logic [1:0]            w_cap_idx;
  logic [3:0]            w_new_code;
  logic                  r_key_valid;
  logic [3:0]            r_key_code;
  logic [7:0]            r_amount;
  logic [1:0]            r_digit_cnt;
  logic                  r_overflow;
  logic                  r_enter;
  logic                  r_entry_done;
  logic [11:0]           w_acc_sum;
  logic                  w_is_digit;

  assign w_tick = &r_div;
  assign w_one_low = (r_col_s2 == 4'b1110) || (r_col_s2 == 4'b1101) ||
                     (r_col_s2 == 4'b1011) || (r_col_s2 == 4'b0111);

  always_comb begin
    w_cap_idx = 2'd0;
    case (r_cap)
      4'b1101: w_cap_idx = 2'd1;
      4'b1011: w_cap_idx = 2'd2;
      4'b0111: w_cap_idx = 2'd3;
      default: w_cap_idx = 2'd0;
    endcase
  end

  // Row is fixed during DEBOUNCE/HOLD, so the live row index is the captured one.
  assign w_new_code = KEY_MAP[{r_row_idx, w_cap_idx}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_col_s1  <= 4'hF;
      r_col_s2  <= 4'hF;
      r_state   <= ST_SCAN;
      r_cnt     <= 4'd0;
      r_cap     <= 4'hF;
      r_row_idx <= 2'd0;
    end else begin
      r_div     <= r_div + 1'b1;
      r_col_s1  <= col;
      r_col_s2  <= r_col_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cap     <= w_cap_nxt;
      r_row_idx <= w_row_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_cap_nxt     = r_cap;
    w_row_idx_nxt = r_row_idx;
    w_kv_nxt      = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_SCAN: begin
          if (w_one_low) begin
            w_cap_nxt   = r_col_s2;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (r_col_s2 == r_cap) begin
            if (r_cnt + 4'd1 == DB_N) begin
              w_kv_nxt    = 1'b1;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_HOLD;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (r_col_s2 == 4'hF) begin
            if (r_cnt + 4'd1 == DB_N) begin
              w_cnt_nxt   = 4'd0;
              w_state_nxt = ST_SCAN;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_cnt_nxt = 4'd0;
          end
        end
        default: w_state_nxt = ST_SCAN;
      endcase
    end
  end

  // 12-bit sum: 255*10+9 fits, so the range check cannot be fooled by wrap-around.
  assign w_acc_sum  = 12'(r_amount) * 12'd10 + 12'(r_key_code);
  assign w_is_digit = (r_key_code <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid  <= 1'b0;
      r_key_code   <= 4'd0;
      r_amount     <= 8'd0;
      r_digit_cnt  <= 2'd0;
      r_overflow   <= 1'b0;
      r_enter      <= 1'b0;
      r_entry_done <= 1'b0;
    end else begin
      r_key_valid <= w_kv_nxt;
      r_enter     <= 1'b0;
      if (w_kv_nxt) begin
        r_key_code <= w_new_code;
      end
      if (clear || (r_key_valid && r_key_code == 4'd14)) begin
        r_amount     <= 8'd0;
        r_digit_cnt  <= 2'd0;
        r_overflow   <= 1'b0;
        r_entry_done <= 1'b0;
      end else if (r_key_valid) begin
        if (w_is_digit) begin
          if (r_entry_done) begin
            r_amount     <= {4'd0, r_key_code};
            r_digit_cnt  <= 2'd1;
            r_overflow   <= 1'b0;
            r_entry_done <= 1'b0;
          end else if (r_digit_cnt != 2'd3 && w_acc_sum <= 12'd255) begin
            r_amount    <= w_acc_sum[7:0];
            r_digit_cnt <= r_digit_cnt + 2'd1;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (r_key_code == 4'd15) begin
          r_enter      <= 1'b1;
          r_entry_done <= 1'b1;
        end
      end
    end
  end

  assign row       = ~(4'd1 << r_row_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign amount    = r_amount;
  assign digit_cnt = r_digit_cnt;
  assign overflow  = r_overflow;
  assign enter     = r_enter;

endmodule

// File: tb/tb_keypad_amount_entry.sv
// Bench for keypad_amount_entry: physical keypad model, directed scenarios, then random key sequences
// scored against an arithmetic model of the amount entry rules.
`timescale 1ns/1ps
module tb_keypad_amount_entry;

  localparam int TICK = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [3:0] row, col, key_code;
  logic       key_valid, overflow, enter;
  logic [7:0] amount;
  logic [1:0] digit_cnt;
  logic [3:0] keys_down [4];

  int checks = 0;
  int failures = 0;
  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  int m_amt, m_cnt;
  bit m_ovf, m_done;

  always #5 clk = ~clk;

  // Pressed switch connects the low row to its column; pull-ups elsewhere.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r]) col = col & ~keys_down[r];
  end

  keypad_amount_entry #(.SCAN_DIV_W(4), .DEBOUNCE_SCANS(4)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .clear(clear),
    .key_valid(key_valid), .key_code(key_code), .amount(amount),
    .digit_cnt(digit_cnt), .overflow(overflow), .enter(enter)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit row_ok(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
  endfunction

  task automatic model_reset();
    m_amt = 0; m_cnt = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic model_key(input int code, input bit clr, output bit exp_enter);
    exp_enter = 0;
    if (clr || code == 14) begin
      model_reset();
    end else if (code <= 9) begin
      if (m_done) begin
        m_amt = code; m_cnt = 1; m_ovf = 0; m_done = 0;
      end else if (m_cnt < 3 && m_amt * 10 + code <= 255) begin
        m_amt = m_amt * 10 + code; m_cnt++;
      end else begin
        m_ovf = 1;
      end
    end else if (code == 15) begin
      m_done = 1; exp_enter = 1;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_amount"}, amount, m_amt);
    check_eq({tag, "_digit_cnt"}, digit_cnt, m_cnt);
    check_eq({tag, "_overflow"}, overflow, m_ovf);
  endtask

  task automatic step(input int n, output int pulses, output int enters, output int rot);
    logic [3:0] prev;
    pulses = 0; enters = 0; rot = 0; prev = row;
    repeat (n) begin
      @(negedge clk);
      if (key_valid === 1'b1) pulses++;
      if (enter === 1'b1) enters++;
      if (row !== prev) rot++;
      prev = row;
      check_eq("row_onehot", row_ok(row), 1);
    end
  endtask

  task automatic wait_row(input logic [3:0] target);
    int n = 0;
    while (row !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("row_reached", row, target);
  endtask

  task automatic press(input int code, input bit clr_kv, input int hold_cyc);
    int idx, waited, p, e, r;
    bit got, exp_en;
    idx = 0;
    for (int i = 0; i < 16; i++) if (kmap[i] == code) idx = i;
    keys_down[idx / 4][idx % 4] = 1'b1;
    got = 0; waited = 0;
    while (!got && waited < 800) begin
      @(negedge clk);
      waited++;
      if (key_valid === 1'b1) got = 1;
    end
    check_eq("kv_seen", got, 1);
    if (got) begin
      check_eq("key_code", key_code, code);
      if (clr_kv) clear = 1'b1;
      model_key(code, clr_kv, exp_en);
      @(negedge clk);
      clear = 1'b0;
      check_eq("enter", enter, exp_en);
      check_eq("kv_one_cycle", key_valid, 0);
      check_state("after_key");
    end
    step(hold_cyc, p, e, r);
    check_eq("hold_no_kv", p, 0);
    keys_down[idx / 4][idx % 4] = 1'b0;
    step(10 * TICK, p, e, r);
    check_eq("release_no_kv", p, 0);
    check_eq("release_no_enter", e, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p, e, r, code;
    int pulses_total;
    for (int i = 0; i < 4; i++) keys_down[i] = 4'h0;
    rst_n = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_row", row, 4'b1110);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_key_code", key_code, 0);
    check_eq("rst_enter", enter, 0);
    check_state("rst");
    rst_n = 1'b1;

    // Clean entry 1,2,8,#
    press(1, 0, 0); press(2, 0, 0); press(8, 0, 0); press(15, 0, 0);
    // Overflow by value, then '*'
    press(2, 0, 0); press(5, 0, 0); press(6, 0, 0); press(14, 0, 0);
    // Overflow by digit count, then '#' and a fresh digit
    press(1, 0, 0); press(2, 0, 0); press(3, 0, 0); press(4, 0, 0);
    press(15, 0, 0); press(7, 0, 0);

    // Short press followed by bouncing on '5'
    pulses_total = 0;
    wait_row(4'b1101);
    keys_down[1][1] = 1'b1;
    step(2 * TICK, p, e, r); pulses_total += p;
    repeat (12) begin
      keys_down[1][1] = ~keys_down[1][1];
      step(TICK, p, e, r); pulses_total += p;
    end
    keys_down[1][1] = 1'b0;
    step(10 * TICK, p, e, r); pulses_total += p;
    check_eq("bounce_no_kv", pulses_total, 0);
    check_state("bounce");

    // Long hold: exactly one report
    press(5, 0, 100 * TICK);

    // Two columns low on r1
    keys_down[1] = 4'b0011;
    step(12 * TICK, p, e, r);
    check_eq("two_col_no_kv", p, 0);
    check_eq("two_col_rotating", (r >= 8), 1);
    keys_down[1] = 4'b0000;
    step(2 * TICK, p, e, r);

    // clear coincident with key_valid
    press(9, 1, 0);

    // Reset in the middle of a debounce
    press(3, 0, 0);
    wait_row(4'b1101);
    keys_down[1][1] = 1'b1;
    step(40, p, e, r);
    check_eq("pre_rst_no_kv", p, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_row", row, 4'b1110);
    check_eq("mid_rst_key_valid", key_valid, 0);
    check_eq("mid_rst_key_code", key_code, 0);
    check_eq("mid_rst_enter", enter, 0);
    check_state("mid_rst");
    keys_down[1][1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(10 * TICK, p, e, r);
    check_eq("post_rst_no_kv", p, 0);

    // Randomised sequences
    repeat (30) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_reset();
        check_state("idle_clear");
      end
      if ($urandom_range(0, 9) < 7) code = $urandom_range(0, 9);
      else code = kmap[$urandom_range(0, 15)];
      press(code, ($urandom_range(0, 9) == 0), $urandom_range(0, 3) * TICK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_amount_entry.md
Name: keypad_amount_entry

Overview:
- Scans a 4x4 matrix keypad, debounces key presses, and reports each press as a key code.
- Accumulates decimal digit keys into an 8-bit binary amount (0-255) for the ATM FSM, which uses it for withdraw and deposit requests.
- It is the input-side counterpart of the balance 7-segment display. The display scans anodes and converts binary to decimal digits. This block scans keypad rows and converts decimal digits to binary.

Parameters:
- SCAN_DIV_W, 15, width of the row-period divider. Row period is 2^SCAN_DIV_W clk cycles; sims use 4.
- DEBOUNCE_SCANS, 4, number of consecutive matching sample ticks required for both press and release; range 2-15.

Ports:
- clk  input  1  100 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- row  output  4  keypad row drive, active low, exactly one bit low at any time
- col  input  4  keypad columns, active low with external pull-ups, asynchronous
- clear  input  1  synchronous one-cycle clear request from the ATM FSM
- key_valid  output  1  one-cycle pulse: a debounced key press was detected
- key_code  output  4  code of the last key, held until the next key_valid
- amount  output  8  accumulated binary amount
- digit_cnt  output  2  number of digits accepted so far (0-3)
- overflow  output  1  sticky flag: a digit was rejected
- enter  output  1  one-cycle pulse when the '#' key is accepted

Behaviour:
- Reset values:
  - row=4'b1110; key_valid=0; key_code=0; amount=0; digit_cnt=0; overflow=0; enter=0.
  - Divider=0, debounce count=0, FSM=SCAN, entry_done=0.
  - Reset takes effect immediately, including mid-scan and mid-debounce.
- Key map, listed as row r / col c -> code:
  - r0: 1,2,3,A -> 1,2,3,10
  - r1: 4,5,6,B -> 4,5,6,11
  - r2: 7,8,9,C -> 7,8,9,12
  - r3: *,0,#,D -> 14,0,15,13
- col passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Divider: free-running SCAN_DIV_W-bit counter. A sample tick occurs in the cycle where the divider is all ones, so columns settle for a full period before sampling.
- SCAN state:
  - On each tick, if exactly one synchronized col bit is low: capture row index and col pattern, set debounce count=1, go to DEBOUNCE. row stays fixed.
  - Otherwise, rotate row low one position (r0->r1->r2->r3->r0) on the cycle after the tick.
  - Zero or multiple col bits low means no event.
- DEBOUNCE state, on each tick:
  - Pattern equals the captured pattern: increment count. When count reaches DEBOUNCE_SCANS, pulse key_valid for 1 cycle (the cycle after that tick), load key_code, go to HOLD.
  - Pattern differs: go to SCAN and resume rotating from the held row.
- HOLD state:
  - row stays fixed; no further key_valid is generated for this press.
  - Count ticks with all col bits high. Any tick with a col bit low resets the count to 0.
  - After DEBOUNCE_SCANS consecutive all-high ticks, go to SCAN.
- Accumulator: acts on key_valid (cycle N); results are visible from cycle N+1.
  - Digit d, entry_done=0, digit_cnt<3, and amount*10+d <= 255: amount = amount*10+d, digit_cnt++.
  - Digit d, entry_done=0, and the above conditions fail: amount and digit_cnt unchanged, overflow=1.
  - Digit d with entry_done=1: start a new entry: amount=d, digit_cnt=1, overflow=0, entry_done=0.
  - '*': amount=0, digit_cnt=0, overflow=0, entry_done=0.
  - '#': enter=1 for exactly cycle N+1, entry_done=1, amount held. '#' with digit_cnt=0 still pulses enter (amount=0).
  - A-D: key_valid only; no accumulator effect.
  - Arithmetic is done at 12-bit width before the comparison, so no wrap-around is possible. amount never exceeds 255.
- clear input:
  - Same effect as '*'; takes priority over a key_valid in the same cycle. That key is still reported on key_valid/key_code but is not accumulated, and no enter is produced.
  - clear does not disturb the scan/debounce FSM.

Test Plan (SCAN_DIV_W=4, DEBOUNCE_SCANS=4):
- Press and release '1','2','8','#' cleanly -> four key_valid pulses with codes 1,2,8,15; amount=128, digit_cnt=3, enter one cycle, overflow=0.
- Keys '2','5','6' -> after '6' amount=25, digit_cnt=2, overflow=1. Then '*' -> amount=0, digit_cnt=0, overflow=0.
- Keys '1','2','3','4' -> amount=123, overflow=1. Then '#','7' -> enter pulse, then amount=7, digit_cnt=1.
- '5' held low for only 2 ticks, then bouncing high/low -> no key_valid. Same key held for 100 ticks -> exactly one key_valid, code 5.
- Two columns low on row r1 -> no key_valid and row keeps rotating. Check row is one-hot-low every cycle.
- Drive clear in the same cycle as key_valid for '9' -> key_code=9 reported, amount=0. Assert rst_n=0 mid-DEBOUNCE -> outputs reach reset values with no clock edge, and no key_valid after release.
